// File: rtl/sorter_checker.sv
// sorter_checker: verifies a sorter result against its source vector.
// Checks ascending order and permutation, one element per cycle.
module sorter_checker #(
    parameter int data_width = 3,
    parameter int num_elem   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [num_elem*data_width-1:0] inps,
    input  logic [num_elem*data_width-1:0] outp,
    output logic                           done,
    output logic                           pass,
    output logic                           err_order,
    output logic                           err_perm,
    output logic [15:0]                    check_count,
    output logic [15:0]                    fail_count
);

    localparam int IW = (num_elem > 1) ? $clog2(num_elem) : 1;
    localparam int CW = $clog2(num_elem + 1);
    localparam logic [IW-1:0] LAST = IW'(num_elem - 1);

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [IW-1:0]                  idx;
    logic [num_elem*data_width-1:0] in_q;
    logic [num_elem*data_width-1:0] out_q;
    logic                           ord_f;
    logic                           perm_f;
    logic [data_width-1:0]          cur;
    logic [data_width-1:0]          prev;
    logic [CW-1:0]                  cnt_in;
    logic [CW-1:0]                  cnt_out;
    logic                           ord_hit;
    logic                           perm_hit;
    logic                           last;
    logic                           take;
    logic                           ord_fin;
    logic                           perm_fin;

    // Select element idx and its predecessor, and count matches of it.
    always_comb begin
        cur     = out_q[data_width-1:0];
        prev    = out_q[data_width-1:0];
        cnt_in  = '0;
        cnt_out = '0;
        for (int i = 1; i < num_elem; i++) begin
            if (idx == IW'(i)) begin
                cur  = out_q[i*data_width +: data_width];
                prev = out_q[(i-1)*data_width +: data_width];
            end
        end
        for (int i = 0; i < num_elem; i++) begin
            if (in_q[i*data_width +: data_width] == cur)
                cnt_in = cnt_in + CW'(1);
            if (out_q[i*data_width +: data_width] == cur)
                cnt_out = cnt_out + CW'(1);
        end
    end

    assign ord_hit  = (idx != '0) && (prev > cur);
    assign perm_hit = (cnt_in != cnt_out);
    assign last     = (idx == LAST);
    assign take     = in_valid && in_ready;
    assign ord_fin  = ord_f | ord_hit;
    assign perm_fin = perm_f | perm_hit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (last) state_nxt = REPORT;
            end
            REPORT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture, per-element checking and result/counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q        <= '0;
            out_q       <= '0;
            idx         <= '0;
            ord_f       <= 1'b0;
            perm_f      <= 1'b0;
            pass        <= 1'b0;
            err_order   <= 1'b0;
            err_perm    <= 1'b0;
            check_count <= '0;
            fail_count  <= '0;
        end else if (take) begin
            in_q   <= inps;
            out_q  <= outp;
            idx    <= '0;
            ord_f  <= 1'b0;
            perm_f <= 1'b0;
        end else if (state == CHECK) begin
            idx    <= last ? '0 : idx + IW'(1);
            ord_f  <= ord_fin;
            perm_f <= perm_fin;
            if (last) begin
                err_order <= ord_fin;
                err_perm  <= perm_fin;
                pass      <= ~(ord_fin | perm_fin);
                if (check_count != 16'hFFFF)
                    check_count <= check_count + 16'd1;
                if ((ord_fin | perm_fin) && fail_count != 16'hFFFF)
                    fail_count <= fail_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sorter_checker.sv
// tb_sorter_checker: directed scenarios for sorter_checker.
// num_elem=4, data_width=3.
module tb_sorter_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] inps = '0;
    logic [11:0] outp = '0;
    logic        done;
    logic        pass;
    logic        err_order;
    logic        err_perm;
    logic [15:0] check_count;
    logic [15:0] fail_count;

    int n_tests = 0;
    int n_fail  = 0;

    sorter_checker #(.data_width(3), .num_elem(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inps(inps), .outp(outp), .done(done), .pass(pass),
        .err_order(err_order), .err_perm(err_perm),
        .check_count(check_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    // One transfer; returns number of negedges after the transfer edge
    // until done is seen (0 on timeout). Returns in the REPORT cycle.
    task automatic do_check(input logic [11:0] i, input logic [11:0] o,
                            output int lat);
        @(negedge clk);
        inps = i;
        outp = o;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #3;
        n_tests++;
        if ({in_ready, done, pass, err_order, err_perm} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 10000",
                     {in_ready, done, pass, err_order, err_perm});
        end
        n_tests++;
        if ({check_count, fail_count} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts got %h exp 0",
                     {check_count, fail_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sorted;
        int lat;
        do_check(pk(3,1,2,0), pk(0,1,2,3), lat);
        n_tests++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL s1_latency got %0d exp 5", lat);
        end
        n_tests++;
        if ({pass, err_order, err_perm} !== 3'b100) begin
            n_fail++;
            $display("FAIL s1_flags got %b exp 100",
                     {pass, err_order, err_perm});
        end
        n_tests++;
        if (check_count !== 16'd1 || fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL s1_counts got %0d/%0d exp 1/0",
                     check_count, fail_count);
        end
    endtask

    task automatic test_order;
        int lat;
        do_check(pk(3,1,2,0), pk(0,2,1,3), lat);
        n_tests++;
        if (lat !== 5 || {pass, err_order, err_perm} !== 3'b010) begin
            n_fail++;
            $display("FAIL s2_flags got lat %0d %b exp lat 5 010",
                     lat, {pass, err_order, err_perm});
        end
        n_tests++;
        if (check_count !== 16'd2 || fail_count !== 16'd1) begin
            n_fail++;
            $display("FAIL s2_counts got %0d/%0d exp 2/1",
                     check_count, fail_count);
        end
    endtask

    task automatic test_perm;
        int lat;
        do_check(pk(3,1,2,0), pk(0,1,2,2), lat);
        n_tests++;
        if (lat !== 5 || {pass, err_order, err_perm} !== 3'b001) begin
            n_fail++;
            $display("FAIL s3_flags got lat %0d %b exp lat 5 001",
                     lat, {pass, err_order, err_perm});
        end
        n_tests++;
        if (check_count !== 16'd3 || fail_count !== 16'd2) begin
            n_fail++;
            $display("FAIL s3_counts got %0d/%0d exp 3/2",
                     check_count, fail_count);
        end
    endtask

    task automatic test_dups;
        int lat;
        do_check(pk(5,5,1,1), pk(1,1,5,5), lat);
        n_tests++;
        if (lat !== 5 || {pass, err_order, err_perm} !== 3'b100) begin
            n_fail++;
            $display("FAIL s4a_flags got lat %0d %b exp lat 5 100",
                     lat, {pass, err_order, err_perm});
        end
        do_check(pk(7,7,7,7), pk(7,7,7,7), lat);
        n_tests++;
        if (lat !== 5 || {pass, err_order, err_perm} !== 3'b100) begin
            n_fail++;
            $display("FAIL s4b_flags got lat %0d %b exp lat 5 100",
                     lat, {pass, err_order, err_perm});
        end
        n_tests++;
        if (check_count !== 16'd5 || fail_count !== 16'd2) begin
            n_fail++;
            $display("FAIL s4_counts got %0d/%0d exp 5/2",
                     check_count, fail_count);
        end
    endtask

    task automatic test_both_errors;
        int lat;
        do_check(pk(3,1,2,0), pk(3,0,0,0), lat);
        n_tests++;
        if (lat !== 5 || {pass, err_order, err_perm} !== 3'b011) begin
            n_fail++;
            $display("FAIL both_flags got lat %0d %b exp lat 5 011",
                     lat, {pass, err_order, err_perm});
        end
        n_tests++;
        if (check_count !== 16'd6 || fail_count !== 16'd3) begin
            n_fail++;
            $display("FAIL both_counts got %0d/%0d exp 6/3",
                     check_count, fail_count);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_rdy;
        logic exp_done;
        @(negedge clk);
        inps = pk(3,1,2,0);
        outp = pk(0,1,2,3);
        in_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_rdy  = (k == 6 || k == 12);
            exp_done = (k == 5 || k == 11);
            n_tests++;
            if (in_ready !== exp_rdy || done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_hs k=%0d got rdy %b done %b exp %b %b",
                         k, in_ready, done, exp_rdy, exp_done);
            end
            if (k == 5) begin
                n_tests++;
                if (pass !== 1'b1 || err_order !== 1'b0 ||
                    check_count !== 16'd7) begin
                    n_fail++;
                    $display("FAIL b2b_first got pass %b eo %b cc %0d exp 1 0 7",
                             pass, err_order, check_count);
                end
            end
            if (k == 11) begin
                n_tests++;
                if ({pass, err_order, err_perm} !== 3'b010 ||
                    check_count !== 16'd8 || fail_count !== 16'd4) begin
                    n_fail++;
                    $display("FAIL b2b_second got %b %0d/%0d exp 010 8/4",
                             {pass, err_order, err_perm},
                             check_count, fail_count);
                end
            end
            if (k == 2) outp = pk(3,2,1,0);
            if (k == 7) outp = pk(0,1,2,3);
            if (k == 12) in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        @(negedge clk);
        inps = pk(3,1,2,0);
        outp = pk(0,2,1,3);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, done, pass, err_order, err_perm} !== 5'b10000 ||
            {check_count, fail_count} !== 32'd0) begin
            n_fail++;
            $display("FAIL s6_reset got %b %0d/%0d exp 10000 0/0",
                     {in_ready, done, pass, err_order, err_perm},
                     check_count, fail_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_tests++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL s6_nodone got done %0d rdy %b exp 0 1",
                     seen, in_ready);
        end
        do_check(pk(3,1,2,0), pk(0,1,2,3), lat);
        n_tests++;
        if (lat !== 5 || pass !== 1'b1 || check_count !== 16'd1 ||
            fail_count !== 16'd0) begin
            n_fail++;
            $display("FAIL s6_after got lat %0d pass %b %0d/%0d exp 5 1 1/0",
                     lat, pass, check_count, fail_count);
        end
    endtask

    initial begin
        test_reset;
        test_sorted;
        test_order;
        test_perm;
        test_dups;
        test_both_errors;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sorter_checker.md
SORTER_CHECKER -- requirements
Module: sorter_checker

Interface
REQ-001 Parameter data_width, default 3: width in bits of each unsigned element.
REQ-002 Parameter num_elem, default 4: number of elements per vector; SHALL be at least 2.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 in_valid  input  1: inps and outp hold a vector pair to check.
REQ-006 in_ready  output  1: checker can accept a vector pair.
REQ-007 inps  input  num_elem*data_width: unsorted source vector; element i occupies bits [i*data_width +: data_width].
REQ-008 outp  input  num_elem*data_width: sorter result vector, packed the same way as inps.
REQ-009 done  output  1: one-cycle pulse when a check completes.
REQ-010 pass  output  1: last completed check found no error.
REQ-011 err_order  output  1: last completed check found an element smaller than its predecessor.
REQ-012 err_perm  output  1: last completed check found that outp is not a permutation of inps.
REQ-013 check_count  output  16: number of completed checks.
REQ-014 fail_count  output  16: number of completed checks with pass=0.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CHECK and REPORT.
REQ-016 In IDLE, in_ready SHALL be 1; in CHECK and REPORT, in_ready SHALL be 0.
REQ-017 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; at that edge the block SHALL capture inps and outp, clear index idx to 0, clear the internal error flags, and enter CHECK.
REQ-018 in_valid while in_ready=0 SHALL be ignored; the captured vectors SHALL NOT change until the next transfer.
REQ-019 Each cycle in CHECK SHALL examine captured outp element idx.
REQ-020 Order check: if idx>0 and element idx-1 > element idx (unsigned compare), the internal order error flag SHALL be set.
REQ-021 Permutation check: if the number of captured inps elements equal to outp element idx differs from the number of captured outp elements equal to it, the internal permutation error flag SHALL be set.
REQ-022 Internal error flags SHALL be sticky for the duration of one check.
REQ-023 idx SHALL increment by 1 per CHECK cycle; at the edge where idx=num_elem-1, the FSM SHALL enter REPORT.
REQ-024 REPORT SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 Latency: if the transfer happens at edge E, done SHALL be 1 exactly in the cycle following edge E+num_elem.
REQ-026 At the edge entering REPORT, err_order and err_perm SHALL load the final internal flags, pass SHALL load NOR of those flags, check_count SHALL increment, and fail_count SHALL increment if pass loads 0.
REQ-027 pass, err_order and err_perm SHALL hold their values until the next REPORT.
REQ-028 check_count and fail_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 Duplicate values SHALL be legal; equal neighbours SHALL NOT set the order error flag.
REQ-030 The next transfer SHALL be possible no earlier than the edge after REPORT, giving a throughput of one check per num_elem+2 cycles.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE and in_ready=1.
REQ-032 While rst_n=0, done, pass, err_order, err_perm, check_count, fail_count, idx, the internal flags and the captured vectors SHALL all be 0.
REQ-033 Reset asserted during CHECK or REPORT SHALL abort the check immediately, with no count update, and the block SHALL resume in IDLE after release.

Verification (num_elem=4, data_width=3, element lists given as index 0..3)
REQ-034 Scenario 1: inps {3,1,2,0}, outp {0,1,2,3} -> done 5 cycles after the transfer edge; pass=1, err_order=0, err_perm=0, check_count=1.
REQ-035 Scenario 2: inps {3,1,2,0}, outp {0,2,1,3} -> pass=0, err_order=1, err_perm=0, fail_count=1.
REQ-036 Scenario 3: inps {3,1,2,0}, outp {0,1,2,2} -> pass=0, err_order=0, err_perm=1.
REQ-037 Scenario 4: inps {5,5,1,1}, outp {1,1,5,5} -> pass=1; then inps {7,7,7,7}, outp {7,7,7,7} -> pass=1 and check_count increments.
REQ-038 Scenario 5: in_valid held at 1 continuously -> in_ready=0 during CHECK and REPORT; new vectors changed mid-check do not affect the result; back-to-back checks occur every 6 cycles.
REQ-039 Scenario 6: rst_n pulsed low during CHECK idx=2 -> no done pulse; all outputs 0; in_ready=1; the next check completes normally with check_count=1.
